// File: rtl/modular_stream_cipher.sv
// Modular stream cipher: encrypts/decrypts an N-character message mod MOD_P with valid/ready I/O.
// Optional per-position rolling key enabled by defining KEY_ROLL_EN.
module modular_stream_cipher #(
   parameter int unsigned       DATA_W  = 8,
   parameter int unsigned       MOD_P   = 227,
   parameter logic [DATA_W-1:0] CHAR_LO = 8'h61,
   parameter logic [DATA_W-1:0] CHAR_HI = 8'h7A,
   parameter int unsigned       LEN_W   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] key,
   input  logic [LEN_W-1:0]  msg_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_err,
   output logic              busy,
   output logic              done,
   output logic              err_mode
);

   localparam logic [DATA_W:0] ModP    = (DATA_W+1)'(MOD_P);
   localparam logic [1:0]      ModeEnc = 2'b01;
   localparam logic [1:0]      ModeDec = 2'b10;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] key_q, key_d;
   logic [1:0]        mode_q;
   logic [LEN_W-1:0]  len_q, count_q;
   logic              out_valid_q, out_last_q, out_err_q;
   logic [DATA_W-1:0] out_data_q;
   logic              done_q, done_d, err_mode_q, err_mode_d;

   logic              in_hs, out_hs, mode_ok, job_load, last_beat, in_legal;
   logic [DATA_W:0]   key_ext, x_ext, k_ext, sum, diff;
   logic [DATA_W-1:0] key_red, res, result;
`ifdef KEY_ROLL_EN
   logic [DATA_W-1:0] key_roll;
`endif

   assign in_ready  = (state_q == StRun) && (!out_valid_q || out_ready);
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid_q && out_ready;
   assign mode_ok   = (mode == ModeEnc) || (mode == ModeDec);
   assign last_beat = (count_q == len_q - LEN_W'(1));

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_err   = out_err_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign err_mode  = err_mode_q;

   // Arithmetic in DATA_W+1 bits; ModP > 2^(DATA_W-1) so one conditional correction suffices.
   always_comb begin
      key_ext = {1'b0, key};
      key_red = (key_ext >= ModP) ? DATA_W'(key_ext - ModP) : key;
      x_ext   = {1'b0, in_data};
      k_ext   = {1'b0, key_q};
      sum     = x_ext + k_ext;
      diff    = x_ext - k_ext;
      if (mode_q == ModeEnc) begin
         in_legal = (in_data >= CHAR_LO) && (in_data <= CHAR_HI);
         res      = (sum >= ModP) ? DATA_W'(sum - ModP) : DATA_W'(sum);
      end else begin
         in_legal = (x_ext < ModP);
         res      = diff[DATA_W] ? DATA_W'(diff + ModP) : DATA_W'(diff);
      end
      result = in_legal ? res : '0;
   end

`ifdef KEY_ROLL_EN
   assign key_roll = (k_ext + (DATA_W+1)'(1) == ModP) ? '0 : key_q + DATA_W'(1);
`endif

   always_comb begin
      key_d = key_q;
      if (job_load) begin
         key_d = key_red;
`ifdef KEY_ROLL_EN
      end else if (in_hs) begin
         key_d = key_roll;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      done_d     = 1'b0;
      err_mode_d = 1'b0;
      job_load   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (!mode_ok) begin
                  err_mode_d = 1'b1;
               end else if (msg_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  job_load = 1'b1;
                  state_d  = StRun;
               end
            end
         end
         StRun: begin
            if (in_hs && last_beat) state_d = StDrain;
         end
         StDrain: begin
            if (out_hs) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         done_q     <= 1'b0;
         err_mode_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         err_mode_q <= err_mode_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q   <= '0;
         mode_q  <= '0;
         len_q   <= '0;
         count_q <= '0;
      end else begin
         key_q <= key_d;
         if (job_load) begin
            mode_q  <= mode;
            len_q   <= msg_len;
            count_q <= '0;
         end else if (in_hs) begin
            count_q <= count_q + LEN_W'(1);
         end
      end
   end

   // An input transfer always reloads the output register, even when the sink drains it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else if (in_hs) begin
         out_valid_q <= 1'b1;
         out_data_q  <= result;
         out_last_q  <= last_beat;
         out_err_q   <= !in_legal;
      end else if (out_hs) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_modular_stream_cipher.sv
// Self-checking bench for modular_stream_cipher: directed vectors plus randomized jobs against a
// modulo-arithmetic reference model.
module tb_modular_stream_cipher;

   localparam int P  = 227;
   localparam int LO = 'h61;
   localparam int HI = 'h7A;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode = '0;
   logic [7:0] key = '0;
   logic [5:0] msg_len = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_last, out_err, busy, done, err_mode;

   int checks = 0;
   int failures = 0;

   logic [7:0] msg   [64];
   logic [7:0] got_d [64];
   logic       got_l [64];
   logic       got_e [64];

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       e;
   } beat_t;

   always #5 clk = ~clk;

   modular_stream_cipher dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .key      (key),
      .msg_len  (msg_len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last),
      .out_err  (out_err),
      .busy     (busy),
      .done     (done),
      .err_mode (err_mode)
   );

   // Returns the result character, or -1 for an illegal input.
   function automatic int ref_char(bit enc, int k, int x);
      if (enc) begin
         if (x < LO || x > HI) return -1;
         return (x + k) % P;
      end
      if (x >= P) return -1;
      return (x - k + P) % P;
   endfunction

   task automatic start_job(input logic [1:0] m, input logic [7:0] k, input int len);
      @(negedge clk);
      start = 1'b1; mode = m; key = k; msg_len = 6'(len);
      @(negedge clk);
      start = 1'b0; mode = '0; key = '0; msg_len = '0;
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL start_busy: busy=%b expected 1", busy);
      end
   endtask

   // vstyle: 0 = in_valid always, 1 = random gaps. rstyle: 0 = ready, 1 = random, 2 = 4-cycle stall.
   task automatic run_job(input logic [1:0] m, input logic [7:0] k, input int len,
                          input int vstyle, input int rstyle);
      beat_t exp_q[$];
      beat_t e;
      int kk, idx, nout, cyc, r;
      bit prev_in, prev_hold, enc;
      logic [7:0] hd;
      logic hl, he;
      enc = (m == 2'b01);
      kk = int'(k) % P;
      idx = 0; nout = 0; cyc = 0; prev_in = 0; prev_hold = 0;
      hd = '0; hl = 0; he = 0;
      start_job(m, k, len);
      while (nout < len && cyc < 2000) begin
         @(negedge clk);
         if (prev_in) begin
            checks++;
            if (out_valid !== 1'b1) begin
               failures++; $display("FAIL latency: out_valid=%b expected 1", out_valid);
            end
         end
         if (prev_hold) begin
            checks++;
            if ({out_valid, out_data, out_last, out_err} !== {1'b1, hd, hl, he}) begin
               failures++;
               $display("FAIL hold: got v=%b %h/%b/%b expected 1 %h/%b/%b",
                        out_valid, out_data, out_last, out_err, hd, hl, he);
            end
         end
         checks++;
         if (done !== 1'b0) begin
            failures++; $display("FAIL early_done: done=%b expected 0", done);
         end
         in_valid = (idx < len) && (vstyle == 0 || $urandom_range(0, 2) != 0);
         in_data  = (idx < len) ? msg[idx] : 8'($urandom);
         case (rstyle)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = !(cyc >= 2 && cyc < 6);
         endcase
         if (rstyle == 1) begin
            start = ($urandom_range(0, 5) == 0);
            mode = 2'($urandom); key = 8'($urandom); msg_len = 6'($urandom);
         end
         #1;
         if (out_valid && !out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
               failures++; $display("FAIL ready_bp: in_ready=%b expected 0", in_ready);
            end
         end
         prev_in = in_valid && in_ready;
         if (prev_in) begin
            r = ref_char(enc, kk, int'(in_data));
            e.d = (r < 0) ? 8'h00 : 8'(r);
            e.e = (r < 0);
            e.l = (idx == len - 1);
            exp_q.push_back(e);
            idx++;
`ifdef KEY_ROLL_EN
            kk = (kk + 1) % P;
`endif
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL spurious_beat: data=%h expected no beat", out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_last, out_err} !== {e.d, e.l, e.e}) begin
                  failures++;
                  $display("FAIL beat%0d: got %h/%b/%b expected %h/%b/%b",
                           nout, out_data, out_last, out_err, e.d, e.l, e.e);
               end
            end
            got_d[nout] = out_data; got_l[nout] = out_last; got_e[nout] = out_err;
            nout++;
         end
         prev_hold = out_valid && !out_ready;
         hd = out_data; hl = out_last; he = out_err;
         cyc++;
      end
      in_valid = 1'b0; start = 1'b0; mode = '0; key = '0; msg_len = '0;
      checks++;
      if (nout != len) begin
         failures++; $display("FAIL timeout: beats=%0d expected %0d", nout, len);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL done_pulse: done=%b busy=%b expected 1 0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++; $display("FAIL done_width: done=%b expected 0", done);
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if ({out_valid, out_data, out_last, out_err, done, err_mode, busy, in_ready} !== 14'h0) begin
         failures++;
         $display("FAIL reset: v=%b d=%h l=%b e=%b done=%b em=%b busy=%b rdy=%b expected all 0",
                  out_valid, out_data, out_last, out_err, done, err_mode, busy, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_vectors();
      logic [7:0] exp_abz [3];
      exp_abz = '{8'h66, 8'h67, 8'h7F};
`ifndef KEY_ROLL_EN
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h7A;
      run_job(2'b01, 8'd5, 3, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got_d[i] !== exp_abz[i] || got_l[i] !== (i == 2)) begin
            failures++;
            $display("FAIL abz%0d: got %h last=%b expected %h last=%b", i, got_d[i], got_l[i],
                     exp_abz[i], (i == 2));
         end
      end
`endif
      msg[0] = 8'h03;
      run_job(2'b10, 8'd10, 1, 0, 0);
      checks++;
      if (got_d[0] !== 8'hDC) begin
         failures++; $display("FAIL dec_k10: got %h expected dc", got_d[0]);
      end
      msg[0] = 8'h7A;
      run_job(2'b01, 8'd200, 1, 0, 0);
      checks++;
      if (got_d[0] !== 8'h5F) begin
         failures++; $display("FAIL enc_k200: got %h expected 5f", got_d[0]);
      end
      run_job(2'b01, 8'd230, 1, 0, 0);
      checks++;
      if (got_d[0] !== 8'h7D) begin
         failures++; $display("FAIL enc_k230: got %h expected 7d", got_d[0]);
      end
   endtask

`ifdef KEY_ROLL_EN
   task automatic test_key_roll();
      msg[0] = 8'h61; msg[1] = 8'h61; msg[2] = 8'h61;
      run_job(2'b01, 8'd5, 3, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got_d[i] !== 8'(8'h66 + i)) begin
            failures++; $display("FAIL roll%0d: got %h expected %h", i, got_d[i], 8'(8'h66 + i));
         end
      end
      run_job(2'b01, 8'd226, 2, 0, 0);
      checks++;
      if (got_d[0] !== 8'h60 || got_d[1] !== 8'h61) begin
         failures++; $display("FAIL roll_wrap: got %h %h expected 60 61", got_d[0], got_d[1]);
      end
   endtask
`endif

   task automatic test_invalid();
      msg[0] = 8'h61; msg[1] = 8'h41; msg[2] = 8'h63;
      run_job(2'b01, 8'd5, 3, 0, 0);
      checks++;
      if (got_d[1] !== 8'h00 || got_e[1] !== 1'b1 || got_e[0] !== 1'b0 || got_e[2] !== 1'b0) begin
         failures++;
         $display("FAIL invalid: got d1=%h errs=%b%b%b expected d1=00 errs=010",
                  got_d[1], got_e[0], got_e[1], got_e[2]);
      end
      checks++;
      if (got_l[2] !== 1'b1) begin
         failures++; $display("FAIL invalid_last: got %b expected 1", got_l[2]);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 10; i++) msg[i] = 8'($urandom_range(LO, HI));
      run_job(2'b01, 8'($urandom), 10, 0, 2);
      for (int i = 0; i < 10; i++) msg[i] = 8'($urandom);
      run_job(2'b10, 8'($urandom), 10, 0, 2);
   endtask

   task automatic test_illegal_mode();
      logic [1:0] bad [2];
      bad = '{2'b11, 2'b00};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         start = 1'b1; mode = bad[i]; key = 8'd7; msg_len = 6'd5;
         @(negedge clk);
         start = 1'b0; mode = '0; msg_len = '0;
         checks++;
         if (err_mode !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL err_mode: em=%b busy=%b done=%b expected 1 0 0", err_mode, busy, done);
         end
         @(negedge clk);
         checks++;
         if (err_mode !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL err_mode_width: em=%b busy=%b expected 0 0", err_mode, busy);
         end
      end
   endtask

   task automatic test_zero_len();
      @(negedge clk);
      start = 1'b1; mode = 2'b01; key = 8'd3; msg_len = 6'd0;
      @(negedge clk);
      start = 1'b0; mode = '0; key = '0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || err_mode !== 1'b0) begin
         failures++;
         $display("FAIL zero_len: done=%b busy=%b v=%b em=%b expected 1 0 0 0",
                  done, busy, out_valid, err_mode);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL zero_len_after: done=%b v=%b expected 0 0", done, out_valid);
      end
   endtask

   task automatic test_reset_mid_job();
      start_job(2'b01, 8'd9, 10);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 8'h62; out_ready = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_data, out_last, out_err, done, err_mode, busy, in_ready} !== 14'h0) begin
         failures++;
         $display("FAIL reset_mid: v=%b d=%h l=%b e=%b done=%b em=%b busy=%b rdy=%b expected all 0",
                  out_valid, out_data, out_last, out_err, done, err_mode, busy, in_ready);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      msg[0] = 8'h70; msg[1] = 8'h71;
      run_job(2'b01, 8'd4, 2, 0, 0);
   endtask

   task automatic test_random();
      logic [1:0] m;
      int len;
      for (int j = 0; j < 16; j++) begin
         m = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         len = $urandom_range(1, 24);
         for (int i = 0; i < len; i++) begin
            if (m == 2'b01 && $urandom_range(0, 7) != 0) msg[i] = 8'($urandom_range(LO, HI));
            else msg[i] = 8'($urandom);
         end
         run_job(m, 8'($urandom), len, j % 2, 1);
      end
      for (int i = 0; i < 20; i++) msg[i] = 8'($urandom_range(LO, HI));
      run_job(2'b01, 8'($urandom), 20, 0, 0);
   endtask

   initial begin
      test_reset();
      test_vectors();
`ifdef KEY_ROLL_EN
      test_key_roll();
`endif
      test_invalid();
      test_backpressure();
      test_illegal_mode();
      test_zero_len();
      test_reset_mid_job();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
